// File: rtl/i2c_block_loader_if.sv
// Bus between the I2C slave front end, the SRAM write port and the block loader.
// The master side drives the I2C event strobes; the slave side is the loader itself.
interface i2c_block_loader_if;
    logic        i2c_start;
    logic        i2c_rw;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        i2c_stop;
    logic [63:0] key1;
    logic [63:0] key2;
    logic        keys_valid;
    logic [15:0] sram_addr;
    logic [63:0] sram_wdata;
    logic        sram_write_en;
    logic        data_ready;
    logic [15:0] block_count;
    logic        overflow;
    logic        key_error;

    modport master (
        output i2c_start, i2c_rw, rx_byte, rx_valid, i2c_stop,
        input  key1, key2, keys_valid, sram_addr, sram_wdata, sram_write_en,
        input  data_ready, block_count, overflow, key_error
    );

    modport slave (
        input  i2c_start, i2c_rw, rx_byte, rx_valid, i2c_stop,
        output key1, key2, keys_valid, sram_addr, sram_wdata, sram_write_en,
        output data_ready, block_count, overflow, key_error
    );
endinterface

// File: rtl/i2c_block_loader.sv
// Captures key1/key2 from the first 16 bytes of an I2C write, then packs the remaining bytes
// MSB-first into 64-bit SRAM blocks and pulses data_ready when the transaction completes.
module i2c_block_loader #(
    parameter logic [15:0] BASE_ADDR  = 16'h0000,
    parameter logic [15:0] MAX_BLOCKS = 16'd1024
) (
    input logic               clk,
    input logic               n_rst,
    i2c_block_loader_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StKey1, StKey2, StData, StFlush, StDone} state_e;

    state_e      state_q, state_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [63:0] acc_q, acc_d, acc_next;
    logic [63:0] key1_q, key1_d;
    logic [63:0] key2_q, key2_d;
    logic        keys_valid_q, keys_valid_d;
    logic [15:0] sram_addr_q, sram_addr_d;
    logic [63:0] sram_wdata_q, sram_wdata_d;
    logic        sram_we_q, sram_we_d;
    logic        data_ready_q, data_ready_d;
    logic [15:0] block_count_q, block_count_d;
    logic        overflow_q, overflow_d;
    logic        key_error_q, key_error_d;
    logic        full;

    assign full = (block_count_q == MAX_BLOCKS);

    // Starting a group clears the accumulator, so a flushed partial block is zero-padded.
    always_comb begin
        acc_next = (byte_cnt_q == 3'd0) ? 64'd0 : acc_q;
        acc_next[{~byte_cnt_q, 3'b000} +: 8] = bus.rx_byte;
    end

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        acc_d         = acc_q;
        key1_d        = key1_q;
        key2_d        = key2_q;
        keys_valid_d  = keys_valid_q;
        sram_addr_d   = sram_addr_q;
        sram_wdata_d  = sram_wdata_q;
        sram_we_d     = 1'b0;
        data_ready_d  = 1'b0;
        block_count_d = block_count_q;
        overflow_d    = overflow_q;
        key_error_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.i2c_start && !bus.i2c_rw) begin
                    state_d       = StKey1;
                    byte_cnt_d    = 3'd0;
                    block_count_d = 16'd0;
                    overflow_d    = 1'b0;
                    keys_valid_d  = 1'b0;
                end
            end

            StKey1, StKey2, StData: begin
                if (bus.i2c_start) begin
                    // Abort: any partially assembled block is dropped.
                    byte_cnt_d = 3'd0;
                    if (bus.i2c_rw) begin
                        state_d = StIdle;
                    end else begin
                        state_d       = StKey1;
                        block_count_d = 16'd0;
                        overflow_d    = 1'b0;
                        keys_valid_d  = 1'b0;
                    end
                end else begin
                    if (bus.rx_valid) begin
                        if (state_q == StData && full) begin
                            overflow_d = 1'b1;
                        end else begin
                            acc_d      = acc_next;
                            byte_cnt_d = byte_cnt_q + 3'd1;
                            if (byte_cnt_q == 3'd7) begin
                                if (state_q == StKey1) begin
                                    key1_d  = acc_next;
                                    state_d = StKey2;
                                end else if (state_q == StKey2) begin
                                    key2_d       = acc_next;
                                    keys_valid_d = 1'b1;
                                    state_d      = StData;
                                end else begin
                                    sram_wdata_d  = acc_next;
                                    sram_addr_d   = BASE_ADDR + block_count_q;
                                    sram_we_d     = 1'b1;
                                    block_count_d = block_count_q + 16'd1;
                                end
                            end
                        end
                    end

                    // Stop is judged against the state reached after the coincident byte.
                    if (bus.i2c_stop) begin
                        if (state_d != StData) begin
                            key_error_d = 1'b1;
                            byte_cnt_d  = 3'd0;
                            state_d     = StIdle;
                        end else if (byte_cnt_d != 3'd0) begin
                            sram_wdata_d  = acc_d;
                            sram_addr_d   = BASE_ADDR + block_count_q;
                            sram_we_d     = 1'b1;
                            block_count_d = block_count_q + 16'd1;
                            state_d       = StFlush;
                        end else begin
                            data_ready_d = (block_count_d != 16'd0);
                            state_d      = StDone;
                        end
                    end
                end
            end

            StFlush: begin
                byte_cnt_d   = 3'd0;
                data_ready_d = (block_count_q != 16'd0);
                state_d      = StDone;
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= StIdle;
            byte_cnt_q    <= 3'd0;
            acc_q         <= 64'd0;
            key1_q        <= 64'd0;
            key2_q        <= 64'd0;
            keys_valid_q  <= 1'b0;
            sram_addr_q   <= 16'd0;
            sram_wdata_q  <= 64'd0;
            sram_we_q     <= 1'b0;
            data_ready_q  <= 1'b0;
            block_count_q <= 16'd0;
            overflow_q    <= 1'b0;
            key_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            acc_q         <= acc_d;
            key1_q        <= key1_d;
            key2_q        <= key2_d;
            keys_valid_q  <= keys_valid_d;
            sram_addr_q   <= sram_addr_d;
            sram_wdata_q  <= sram_wdata_d;
            sram_we_q     <= sram_we_d;
            data_ready_q  <= data_ready_d;
            block_count_q <= block_count_d;
            overflow_q    <= overflow_d;
            key_error_q   <= key_error_d;
        end
    end

    assign bus.key1          = key1_q;
    assign bus.key2          = key2_q;
    assign bus.keys_valid    = keys_valid_q;
    assign bus.sram_addr     = sram_addr_q;
    assign bus.sram_wdata    = sram_wdata_q;
    assign bus.sram_write_en = sram_we_q;
    assign bus.data_ready    = data_ready_q;
    assign bus.block_count   = block_count_q;
    assign bus.overflow      = overflow_q;
    assign bus.key_error     = key_error_q;
endmodule

// File: doc/i2c_block_loader.md
# i2c_block_loader

Upstream stage of the Triple-DES datapath. Receives the byte stream of an I2C write transaction from the I2C slave, captures the first 16 bytes as key1/key2, and packs the remaining bytes into 64-bit blocks written to the SRAM buffer at incrementing addresses. At end of transaction it pulses `data_ready`, which is consumed by the main controller to start encryption/decryption.

## Interface
Parameters:
- BASE_ADDR, 16'h0000, SRAM word address of the first data block
- MAX_BLOCKS, 16'd1024, maximum number of data blocks stored per transaction

Ports:
- clk  in  1  system clock, rising-edge
- n_rst  in  1  asynchronous active-low reset
- i2c_start  in  1  one-cycle pulse: START/repeated START detected, address matched
- i2c_rw  in  1  R/W bit of current transaction, valid with i2c_start (0 = write)
- rx_byte  in  8  received data byte
- rx_valid  in  1  one-cycle strobe, rx_byte valid
- i2c_stop  in  1  one-cycle pulse: STOP detected
- key1  out  64  captured key 1
- key2  out  64  captured key 2
- keys_valid  out  1  both keys fully captured in current transaction
- sram_addr  out  16  SRAM word address for write
- sram_wdata  out  64  packed block
- sram_write_en  out  1  one-cycle SRAM write strobe
- data_ready  out  1  one-cycle pulse: transaction complete, blocks in SRAM
- block_count  out  16  blocks written in last/current transaction
- overflow  out  1  sticky: bytes dropped because MAX_BLOCKS reached
- key_error  out  1  one-cycle pulse: STOP before 16 key bytes received

## Operation
- States: IDLE, KEY1, KEY2, DATA, FLUSH, DONE.
- IDLE: i2c_start with i2c_rw=0 -> KEY1; clear byte counter, block_count, overflow, keys_valid. i2c_start with i2c_rw=1 ignored (stay IDLE).
- Byte packing, MSB first: first byte of each 8-byte group goes to [63:56], eighth to [7:0]. 3-bit byte counter wraps 7 -> 0.
- KEY1: 8 bytes -> key1, then KEY2. KEY2: 8 bytes -> key2, keys_valid=1, then DATA.
- DATA: on 8th byte of a group, register block; sram_write_en=1 next cycle with sram_addr = BASE_ADDR + block_count, then block_count += 1.
- block_count == MAX_BLOCKS: further bytes dropped, overflow=1 (sticky until next write START), no writes.
- i2c_stop in DATA: byte counter != 0 -> FLUSH (pad unreceived bytes with 8'h00, one write), then DONE; counter == 0 -> DONE directly. Partial block while full (overflow) is discarded.
- DONE: data_ready=1 for one cycle if block_count > 0; then IDLE. block_count and keys held in IDLE.
- i2c_stop in KEY1/KEY2: key_error pulse next cycle, keys_valid stays 0, -> IDLE, no writes, no data_ready.
- i2c_start (any rw) in KEY1/KEY2/DATA: abort; partial block discarded, no data_ready; rw=0 -> KEY1 (counters cleared), rw=1 -> IDLE.
- rx_valid and i2c_stop same cycle: byte accepted first, then stop handling. rx_valid in IDLE/FLUSH/DONE ignored.

## Timing
- Reset: state IDLE; key1, key2, sram_addr, sram_wdata, block_count = 0; keys_valid, sram_write_en, data_ready, overflow, key_error = 0.
- All outputs registered. Reset mid-transaction returns to IDLE immediately; no partial write.
- 8th byte accepted at edge N -> sram_write_en high cycle N+1, sram_addr/sram_wdata stable in same cycle.
- 16th key byte at edge N -> keys_valid high from cycle N+1.
- Stop at edge S, no partial: data_ready high cycle S+1. Partial: pad write cycle S+1, data_ready cycle S+2.
- Back-to-back rx_valid every cycle supported; at most one SRAM write per 8 bytes, never two consecutive write cycles except final-byte/stop coincidence (write then flush impossible: counter is 0).

## Test plan
- Write: 16 key bytes 01..10 + 16 data bytes 20..2F + STOP -> key1=0x0102030405060708, key2=0x090A0B0C0D0E0F10; writes addr 0x0000=0x2021..27, 0x0001=0x2829..2F; data_ready one cycle after STOP; block_count=2.
- Partial block: keys + 3 bytes AA BB CC + STOP -> FLUSH write 0xAABBCC0000000000 at BASE_ADDR cycle S+1; data_ready cycle S+2; block_count=1.
- Early STOP after 10 bytes -> key_error pulse, keys_valid=0, no sram_write_en, no data_ready.
- MAX_BLOCKS=2, keys + 24 data bytes + STOP -> 2 writes only, overflow=1, data_ready pulse, block_count=2.
- Repeated START (rw=0) after keys + 4 data bytes -> no write, no data_ready, keys_valid=0, next 16 bytes captured as new keys; read START (rw=1) from IDLE -> no state change.
- Reset asserted mid-DATA -> all outputs 0 asynchronously; subsequent full transaction behaves as scenario 1.
